// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_pkg : opcodes and saturating adder for the interval timer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package timer_pkg;

  localparam int c_max_w = 64;

  localparam logic [2:0] c_op_now   = 3'd0;
  localparam logic [2:0] c_op_start = 3'd1;
  localparam logic [2:0] c_op_stop  = 3'd2;
  localparam logic [2:0] c_op_read  = 3'd3;
  localparam logic [2:0] c_op_lap   = 3'd4;
  localparam logic [2:0] c_op_clear = 3'd5;

  // Operands are zero-extended w-bit values; carry is taken from bit w.
  function automatic logic [c_max_w-1:0] sat_add(input logic [c_max_w-1:0] a,
                                                 input logic [c_max_w-1:0] b,
                                                 input logic               sat,
                                                 input int                 w);
    logic [c_max_w:0]   sum;
    logic [c_max_w-1:0] mask;
    mask = {c_max_w{1'b1}} >> (c_max_w - w);
    sum  = {1'b0, a} + {1'b0, b};
    if (sat && sum[w]) return mask;
    return sum[c_max_w-1:0] & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_channel_interval_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_channel_interval_timer_if : command/result handshake bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface multi_channel_interval_timer_if #(
  parameter int CNT_W = 64,
  parameter int CH_W  = 3
);
  logic             ivalid;
  logic             oready;
  logic [2:0]       cmd_op;
  logic [CH_W-1:0]  cmd_ch;
  logic             ovalid;
  logic             iready;
  logic [CNT_W-1:0] result;
  logic             result_err;

  modport master (output ivalid, cmd_op, cmd_ch, iready,
                  input  oready, ovalid, result, result_err);
  modport slave  (input  ivalid, cmd_op, cmd_ch, iready,
                  output oready, ovalid, result, result_err);
endinterface
`default_nettype wire

// File: rtl/timer_free_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_free_cnt : free-running W-bit timestamp counter                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module timer_free_cnt #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         resetn,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!resetn) r_count <= '0;
    else         r_count <= r_count + W'(1);
  end

  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/multi_channel_interval_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_channel_interval_timer : NUM_CH interval channels on a shared  |
// | timestamp with an in-order result buffer.  Rev 1.0                   |
// +----------------------------------------------------------------------+
module multi_channel_interval_timer
  import timer_pkg::*;
#(
  parameter int CNT_W     = 64,
  parameter int NUM_CH    = 8,
  parameter int SATURATE  = 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  multi_channel_interval_timer_if.slave bus
);
  localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_ptr_w = $clog2(OUT_DEPTH);
  localparam int c_cnt_w = $clog2(OUT_DEPTH + 1);

  logic [CNT_W-1:0]   w_now;
  logic [CNT_W-1:0]   r_start [NUM_CH];
  logic [CNT_W-1:0]   r_acc   [NUM_CH];
  logic [NUM_CH-1:0]  r_run;
  logic [CNT_W-1:0]   r_buf_val [OUT_DEPTH];
  logic [OUT_DEPTH-1:0] r_buf_err;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_bad_ch;
  logic               w_err;
  logic [c_ch_w-1:0]  w_ch;
  logic [CNT_W-1:0]   w_elapsed;
  logic [CNT_W-1:0]   w_lap;
  logic [CNT_W-1:0]   w_res;

  timer_free_cnt #(.W(CNT_W)) u_free_cnt (
    .clock  (clock),
    .resetn (resetn),
    .count  (w_now)
  );

  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(OUT_DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign bus.oready     = (r_count < c_cnt_w'(OUT_DEPTH));
  assign bus.ovalid     = (r_count != '0);
  assign bus.result     = bus.ovalid ? r_buf_val[r_rd_ptr] : '0;
  assign bus.result_err = bus.ovalid & r_buf_err[r_rd_ptr];

  assign w_push   = bus.ivalid & bus.oready;
  assign w_pop    = bus.ovalid & bus.iready;
  assign w_bad_ch = (int'(bus.cmd_ch) >= NUM_CH);
  assign w_err    = w_bad_ch | (bus.cmd_op > c_op_clear);
  // Out-of-range channels are steered to 0 so the array reads stay in bounds.
  assign w_ch     = w_bad_ch ? '0 : c_ch_w'(bus.cmd_ch);

  always_comb begin
    w_elapsed = w_now - r_start[w_ch];
    w_lap     = r_run[w_ch]
              ? CNT_W'(sat_add(c_max_w'(r_acc[w_ch]), c_max_w'(w_elapsed),
                               SATURATE != 0, CNT_W))
              : r_acc[w_ch];
    w_res     = '0;
    if (!w_err) begin
      case (bus.cmd_op)
        c_op_now, c_op_start: w_res = w_now;
        c_op_stop, c_op_lap:  w_res = w_lap;
        c_op_read:            w_res = r_acc[w_ch];
        default:              w_res = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_start[i] <= '0;
        r_acc[i]   <= '0;
      end
      for (int i = 0; i < OUT_DEPTH; i++) r_buf_val[i] <= '0;
      r_run     <= '0;
      r_buf_err <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (w_push) begin
        r_buf_val[r_wr_ptr] <= w_res;
        r_buf_err[r_wr_ptr] <= w_err;
        r_wr_ptr            <= f_next(r_wr_ptr);
        if (!w_err) begin
          case (bus.cmd_op)
            c_op_start: begin
              r_start[w_ch] <= w_now;
              r_run[w_ch]   <= 1'b1;
            end
            c_op_stop: begin
              if (r_run[w_ch]) begin
                r_acc[w_ch] <= w_lap;
                r_run[w_ch] <= 1'b0;
              end
            end
            c_op_clear: begin
              r_acc[w_ch] <= '0;
              r_run[w_ch] <= 1'b0;
            end
            default: ;
          endcase
        end
      end
      if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + c_cnt_w'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_cnt_w'(1);
    end
  end
endmodule
`default_nettype wire
